program_sequencer: RTL and testbench



---
 rtl/sequencer_pkg.sv | 23 ++
 rtl/settle_timer.sv | 33 +++
 rtl/program_sequencer.sv | 121 ++++++++++++
 tb/tb_program_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sequencer_pkg.sv
// Shared opcode, state and default definitions for the program sequencer.
// Latency: none (declarations only).
// Backpressure: none.
package sequencer_pkg;

  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_JRS  = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  localparam int DEFAULT_PC_W          = 2;
  // Must be at least 1: the R1/RS ripple needs a full cycle before RS is read.
  localparam int DEFAULT_SETTLE_CYCLES = 2;

endpackage

// File: rtl/settle_timer.sv
// Down-counter that times the R1/RS ripple after a register clock or clear pulse.
// Latency: done is high in the SETTLE_CYCLES-th enabled cycle after load.
// Backpressure: none; load takes priority over counting.
module settle_timer
  import sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
  input  logic CLK,
  input  logic Reset,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  logic [CW-1:0] cnt;

  // Load the remaining settle cycles on EXEC, count down while settling.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(SETTLE_CYCLES - 1);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/program_sequencer.sv
// Fetches/decodes program words and drives the R1/RS register's clock and clear.
// Latency: INC/CLR take 2+SETTLE_CYCLES cycles (pc moves on the last), JRS/HALT take 2.
// Backpressure: run is sampled only in IDLE, FETCH and HALT; instructions always complete.
module program_sequencer
  import sequencer_pkg::*;
#(
  parameter int PC_W          = DEFAULT_PC_W,
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            run,
  input  logic [PC_W+1:0] instr,
  input  logic [1:0]      r_val,
  input  logic            rs,
  output logic [PC_W-1:0] pc,
  output logic            inc_clk,
  output logic            reg_clr,
  output logic            busy,
  output logic            halted
);

  state_t          state;
  logic [PC_W+1:0] ir;
  logic [1:0]      ir_op;
  logic [PC_W-1:0] ir_arg;
  logic            settle_done;
  // r_val is a debug-only readback; no instruction consumes it.
  logic            unused_r_val;

  assign ir_op        = ir[PC_W+1:PC_W];
  assign ir_arg       = ir[PC_W-1:0];
  assign unused_r_val = ^r_val;

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .CLK   (CLK),
    .Reset (Reset),
    .load  (state == ST_EXEC),
    .en    (state == ST_SETTLE),
    .done  (settle_done)
  );

  // Sequencer FSM; every output is a flop so inc_clk is safe to use as a clock.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state   <= ST_IDLE;
      pc      <= '0;
      ir      <= '0;
      inc_clk <= 1'b0;
      reg_clr <= 1'b0;
      busy    <= 1'b0;
      halted  <= 1'b0;
    end else begin
      // Pulses default low so each lasts exactly one cycle.
      inc_clk <= 1'b0;
      reg_clr <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          pc <= '0;
          if (run) begin
            state <= ST_FETCH;
            busy  <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (!run) begin
            state <= ST_IDLE;
            pc    <= '0;
            busy  <= 1'b0;
          end else begin
            ir    <= instr;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (ir_op)
            OP_INC: begin
              inc_clk <= 1'b1;
              state   <= ST_SETTLE;
            end
            OP_CLR: begin
              reg_clr <= 1'b1;
              state   <= ST_SETTLE;
            end
            OP_JRS: begin
              pc    <= rs ? ir_arg : pc + PC_W'(1);
              state <= ST_FETCH;
            end
            default: begin
              state  <= ST_HALT;
              busy   <= 1'b0;
              halted <= 1'b1;
            end
          endcase
        end
        ST_SETTLE: begin
          if (settle_done) begin
            pc    <= pc + PC_W'(1);
            state <= ST_FETCH;
          end
        end
        ST_HALT: begin
          if (!run) begin
            state  <= ST_IDLE;
            pc     <= '0;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          pc     <= '0;
          busy   <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer with an instruction-timeline model.
// Latency: n/a.
// Backpressure: n/a.
module tb_program_sequencer;
  import sequencer_pkg::*;

  localparam int PC_W   = 2;
  localparam int S      = 2;
  localparam int IW     = PC_W + 2;
  localparam int DEPTH  = 1 << PC_W;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic            CLK   = 1'b0;
  logic            Reset = 1'b0;
  logic            run   = 1'b0;
  logic            rs    = 1'b0;
  logic [IW-1:0]   instr;
  logic [1:0]      r_val;
  logic [PC_W-1:0] pc;
  logic            inc_clk;
  logic            reg_clr;
  logic            busy;
  logic            halted;
  logic [IW-1:0]   prog [DEPTH];
  logic [1:0]      reg_q = 2'b00;

  int checks = 0;
  int errors = 0;

  program_sequencer #(.PC_W(PC_W), .SETTLE_CYCLES(S)) dut (
    .CLK     (CLK),
    .Reset   (Reset),
    .run     (run),
    .instr   (instr),
    .r_val   (r_val),
    .rs      (rs),
    .pc      (pc),
    .inc_clk (inc_clk),
    .reg_clr (reg_clr),
    .busy    (busy),
    .halted  (halted)
  );

  initial forever #5 CLK = ~CLK;

  // Combinational program store and a behavioural 2-bit ripple register.
  assign instr = prog[pc];
  assign r_val = reg_q;
  always @(posedge inc_clk or posedge reg_clr) begin
    if (reg_clr) reg_q <= 2'b00;
    else         reg_q <= reg_q + 2'b01;
  end

  function automatic logic [IW-1:0] mk(logic [1:0] op, int arg);
    return {op, PC_W'(arg)};
  endfunction

  // Reference model: an instruction occupies cycle 0 (fetch), 1 (execute), then
  // S settle cycles for INC/CLR; the pc moves at the end of the instruction.
  int         m_mode = M_IDLE;
  int         m_k    = 0;
  int         m_pc   = 0;
  logic [IW-1:0] m_w = '0;
  logic       m_inc  = 1'b0;
  logic       m_clr  = 1'b0;

  initial begin
    forever begin
      @(posedge CLK or negedge Reset);
      m_inc = 1'b0;
      m_clr = 1'b0;
      if (!Reset) begin
        m_mode = M_IDLE;
        m_k    = 0;
        m_pc   = 0;
      end else if (m_mode == M_IDLE) begin
        m_pc = 0;
        if (run) begin
          m_mode = M_RUN;
          m_k    = 0;
        end
      end else if (m_mode == M_HALT) begin
        if (!run) begin
          m_mode = M_IDLE;
          m_pc   = 0;
        end
      end else if (m_k == 0) begin
        if (!run) begin
          m_mode = M_IDLE;
          m_pc   = 0;
        end else begin
          m_w = prog[m_pc];
          m_k = 1;
        end
      end else if (m_k == 1) begin
        if (m_w[IW-1:IW-2] == OP_INC) begin
          m_inc = 1'b1;
          m_k   = 2;
        end else if (m_w[IW-1:IW-2] == OP_CLR) begin
          m_clr = 1'b1;
          m_k   = 2;
        end else if (m_w[IW-1:IW-2] == OP_JRS) begin
          m_pc = rs ? int'(m_w[PC_W-1:0]) : (m_pc + 1) % DEPTH;
          m_k  = 0;
        end else begin
          m_mode = M_HALT;
        end
      end else if (m_k == S + 1) begin
        m_pc = (m_pc + 1) % DEPTH;
        m_k  = 0;
      end else begin
        m_k = m_k + 1;
      end
    end
  end

  int   cyc = 0;
  int   pulses[$];
  int   pc_seq[$];
  int   clrs = 0;
  logic prev_inc = 1'b0;
  logic prev_clr = 1'b0;

  task automatic check(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // One cycle: compare DUT against the model at the falling edge and log events.
  task automatic tick();
    logic [PC_W+3:0] got;
    logic [PC_W+3:0] exp;
    @(negedge CLK);
    cyc++;
    got = {pc, inc_clk, reg_clr, busy, halted};
    exp = {PC_W'(m_pc), m_inc, m_clr, (m_mode == M_RUN), (m_mode == M_HALT)};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL cycle %0d model: got pc=%0d inc=%b clr=%b busy=%b halted=%b, expected pc=%0d inc=%b clr=%b busy=%b halted=%b",
               cyc, pc, inc_clk, reg_clr, busy, halted, m_pc, m_inc, m_clr, (m_mode == M_RUN), (m_mode == M_HALT));
    end
    checks++;
    if ((inc_clk && reg_clr) || (inc_clk && prev_inc) || (reg_clr && prev_clr)) begin
      errors++;
      $display("FAIL cycle %0d pulse_rules: inc=%b clr=%b prev_inc=%b prev_clr=%b, expected single non-overlapping pulses",
               cyc, inc_clk, reg_clr, prev_inc, prev_clr);
    end
    prev_inc = inc_clk;
    prev_clr = reg_clr;
    if (inc_clk === 1'b1) pulses.push_back(cyc);
    if (reg_clr === 1'b1) clrs++;
    if (pc_seq.size() == 0 || int'(pc) != pc_seq[$]) pc_seq.push_back(int'(pc));
  endtask

  task automatic start_prog(logic [IW-1:0] w0, logic [IW-1:0] w1, logic [IW-1:0] w2, logic [IW-1:0] w3);
    prog[0] = w0;
    prog[1] = w1;
    prog[2] = w2;
    prog[3] = w3;
    pulses.delete();
    pc_seq.delete();
    clrs = 0;
  endtask

  task automatic wait_halted(string name, int budget);
    int n = 0;
    while (halted !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(name, int'(halted === 1'b1), 1);
  endtask

  task automatic wait_inc(string name, int budget);
    int n = 0;
    while (inc_clk !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(name, int'(inc_clk === 1'b1), 1);
  endtask

  task automatic go_idle(string name);
    run = 1'b0;
    repeat (8) tick();
    check({name, "_busy"}, int'(busy), 0);
    check({name, "_pc"}, int'(pc), 0);
    check({name, "_halted"}, int'(halted), 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) prog[i] = mk(OP_HALT, 0);

    // Reset state
    repeat (2) tick();
    check("reset_pc", int'(pc), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_halted", int'(halted), 0);
    check("reset_pulses", int'({inc_clk, reg_clr}), 0);
    Reset = 1'b1;
    repeat (2) tick();

    // INC,INC,INC,HALT
    start_prog(mk(OP_INC, 0), mk(OP_INC, 0), mk(OP_INC, 0), mk(OP_HALT, 0));
    run = 1'b1;
    wait_halted("a_halt", 40);
    check("a_pulses", pulses.size(), 3);
    for (int i = 1; i < pulses.size(); i++) check("a_gap", pulses[i] - pulses[i-1], 4);
    check("a_pc_seq_len", pc_seq.size(), 4);
    for (int i = 0; i < pc_seq.size() && i < 4; i++) check("a_pc_seq", pc_seq[i], i);
    check("a_rval", int'(r_val), 3);
    go_idle("a_idle");

    // CLR,INC,JRS 1,HALT with rs=0
    start_prog(mk(OP_CLR, 0), mk(OP_INC, 0), mk(OP_JRS, 1), mk(OP_HALT, 0));
    rs  = 1'b0;
    run = 1'b1;
    wait_halted("b_halt", 40);
    check("b_clrs", clrs, 1);
    check("b_pulses", pulses.size(), 1);
    check("b_pc", int'(pc), 3);
    check("b_pc_seq_len", pc_seq.size(), 4);
    check("b_rval", int'(r_val), 1);
    go_idle("b_idle");

    // Same program, rs=1 loops back to pc=1 until three INC pulses are seen
    start_prog(mk(OP_CLR, 0), mk(OP_INC, 0), mk(OP_JRS, 1), mk(OP_HALT, 0));
    rs  = 1'b1;
    run = 1'b1;
    for (int n = 0; n < 60 && pulses.size() < 3; n++) tick();
    check("c_loop_pulses", pulses.size(), 3);
    rs = 1'b0;
    wait_halted("c_halt", 40);
    check("c_pulses", pulses.size(), 3);
    check("c_pc_seq_len", pc_seq.size(), 8);
    if (pc_seq.size() > 3) check("c_jump_back", pc_seq[3], 1);
    check("c_pc", int'(pc), 3);
    go_idle("c_idle");

    // INC x4 without HALT: pc wraps 3->0 with no stall
    start_prog(mk(OP_INC, 0), mk(OP_INC, 0), mk(OP_INC, 0), mk(OP_INC, 0));
    run = 1'b1;
    repeat (22) tick();
    check("d_pulses", pulses.size(), 5);
    for (int i = 1; i < pulses.size(); i++) check("d_gap", pulses[i] - pulses[i-1], 4);
    if (pc_seq.size() > 4) check("d_wrap", pc_seq[4], 0);
    check("d_pc_seq_min", int'(pc_seq.size() >= 5), 1);
    go_idle("d_idle");

    // run dropped during SETTLE of an INC
    start_prog(mk(OP_INC, 0), mk(OP_INC, 0), mk(OP_INC, 0), mk(OP_INC, 0));
    run = 1'b1;
    wait_inc("e_first_inc", 20);
    run = 1'b0;
    repeat (8) tick();
    check("e_pulses", pulses.size(), 1);
    check("e_pc_seq_len", pc_seq.size(), 3);
    check("e_pc", int'(pc), 0);
    check("e_busy", int'(busy), 0);

    // Asynchronous reset while inc_clk is high in SETTLE
    start_prog(mk(OP_INC, 0), mk(OP_INC, 0), mk(OP_INC, 0), mk(OP_INC, 0));
    run = 1'b1;
    wait_inc("r_inc_seen", 20);
    #1 Reset = 1'b0;
    #1;
    check("r_async_inc", int'(inc_clk), 0);
    check("r_async_pc", int'(pc), 0);
    check("r_async_busy", int'(busy), 0);
    run = 1'b0;
    tick();
    Reset = 1'b1;
    repeat (4) tick();
    check("r_post_busy", int'(busy), 0);

    // Randomized programs, run and rs
    for (int n = 0; n < 600; n++) begin
      if (n % 40 == 0) begin
        for (int i = 0; i < DEPTH; i++) prog[i] = IW'($urandom_range(0, 15));
      end
      run = ($urandom_range(0, 9) != 0);
      rs  = $urandom_range(0, 1) == 1;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
